seg_scan_display: RTL and testbench
===================================

// Module: seg_scan_display
// PURPOSE
//  Parametrised multiplexed 7-segment display engine for the dashboard.
//  Shows FIELDS decimal fields of DIGITS digits each, e.g. RPM | speed.
//  An iterative double-dabble converter snapshots the binary field values on a load handshake.
//  Committed digits are scanned on tick_scan with ghost blanking, per-field blinking, leading-zero blanking and decimal points.
// PARAMETERS
//  FIELDS       2   number of numeric fields; field 0 is rightmost
//  DIGITS       4   digits per field; N = FIELDS*DIGITS, N <= 16
//  VAL_W        14  binary width of each field value
//  BLINK_TICKS  64  tick_scan pulses per blink half-period, >= 1
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous, active-low reset
//  tick_scan in   1          1-clk scan-advance strobe
//  values    in   FIELDS*VAL_W  field f at [f*VAL_W +: VAL_W]
//  load      in   1          request to snapshot and convert values
//  busy      out  1          conversion in progress; load is ignored while high
//  lzb_en    in   FIELDS     per-field leading-zero blanking enable
//  blink_en  in   FIELDS     per-field blink enable
//  dp_mask   in   N          decimal point per digit; bit d drives seg_data[7]
//  seg_data  out  8          segments, active-high, bit0=a .. bit6=g, bit7=dp
//  seg_com   out  N          digit commons, active-low, one-hot-low when driven
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - busy=0, seg_com=all 1, seg_data=0, scan_idx=0.
//   - Blink counter and blink_phase = 0.
//   - All committed digits = 4'hF (blank).
//   - A reset mid-conversion aborts it; nothing is committed.
//  Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   - IDLE: when load=1, capture values and the per-field overflow flag (value > 10^DIGITS-1), then go to SHIFT.
//   - busy=1 from the cycle after load through COMMIT.
//   - SHIFT: exactly VAL_W cycles. All fields shift in parallel; add 3 to every BCD nibble >= 5 before each shift.
//   - COMMIT: 1 cycle, writing all fields' digit registers atomically.
//     - Overflow field: all digits 9.
//     - lzb_en[f]=1: leading zeros become 4'hF; the ones digit is never blanked.
//   - busy falls VAL_W+2 clocks after the load cycle. A new load is accepted in that same cycle.
//  Scan:
//   - Each tick_scan: scan_idx <= (scan_idx==N-1) ? 0 : scan_idx+1.
//   - Outputs are registered. In the clk after a tick, seg_com=all 1 and seg_data=0 (ghost blank). From the following clk, drive digit scan_idx.
//   - Digit d belongs to field d/DIGITS at position d%DIGITS, with position 0 = ones.
//   - Encode: 0..9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F; 4'hF and others -> 00.
//   - seg_data[7] = dp_mask[d], except when the digit is forced blank by blink.
//  Blink:
//   - The counter counts tick_scan, wraps at BLINK_TICKS-1 and toggles blink_phase on wrap.
//   - While blink_en[f] && blink_phase, field f digits output seg_data=0; seg_com keeps scanning.
//  Simultaneous events:
//   - COMMIT and a drive in the same clk: the drive uses the old digits; new digits appear from the next clk.
//   - load and tick_scan together are independent.
// TESTING
//  - Reset: rst_n=0 -> seg_com=8'hFF, seg_data=0, busy=0. After release, a full scan shows seg_data=0 on all digits.
//  - FIELDS=2, DIGITS=4, lzb_en=2'b11, values{1234,56}, load:
//    - busy high for 15 clks after load, then low.
//    - Digits 7..4 = 06,5B,4F,66; digits 3..0 = 00,00,6D,7D.
//  - Value 0 with lzb_en=1: field shows 00,00,00,3F. With lzb_en=0: 3F,3F,3F,3F.
//  - Overflow: VAL_W=14, value 16383 -> all four digits 6F. Value 9999 -> 6F x4 with the overflow flag clear.
//  - Blink: BLINK_TICKS=4, blink_en=2'b01.
//    - Field 0 shows seg_data=0 on ticks 4-7 and is visible on ticks 0-3 and 8-11.
//    - Field 1 is never blanked. dp_mask[0]=1 is also suppressed while blanked.
//  - Wrap/handshake: FIELDS=3, DIGITS=2.
//    - scan_idx goes 5->0, each change preceded by one all-off clk.
//    - load while busy is ignored.
//    - rst_n pulse mid-SHIFT -> busy=0 immediately, all digits blank.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display engine: iterative double-dabble converter
// feeding a scanned digit bank with ghost blanking, blinking and LZ blanking.
module seg_scan_display #(
    parameter int unsigned FIELDS      = 2,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned VAL_W       = 14,
    parameter int unsigned BLINK_TICKS = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_scan,
    input  logic [FIELDS*VAL_W-1:0]    values,
    input  logic                       load,
    output logic                       busy,
    input  logic [FIELDS-1:0]          lzb_en,
    input  logic [FIELDS-1:0]          blink_en,
    input  logic [FIELDS*DIGITS-1:0]   dp_mask,
    output logic [7:0]                 seg_data,
    output logic [FIELDS*DIGITS-1:0]   seg_com
);

    localparam int unsigned N     = FIELDS * DIGITS;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int unsigned BT_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

    state_e                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [FIELDS-1:0][VAL_W-1:0]   bin_q, bin_d, val_in;
    logic [FIELDS-1:0][BCD_W-1:0]   bcd_q, bcd_d;
    logic [FIELDS-1:0]              ovf_q, ovf_in;
    logic                           busy_q;
    logic [N-1:0][3:0]              dig_q, dig_d;

    logic [IDX_W-1:0]               scan_idx_q;
    logic [BT_W-1:0]                blink_cnt_q;
    logic                           blink_phase_q;
    logic [7:0]                     seg_data_q, data_c;
    logic [N-1:0]                   seg_com_q, com_c;

    logic [BCD_W-1:0]               tmp;
    logic                           lead;
    logic [3:0]                     nib;

    // Snapshot unpacking and overflow detection
    always_comb begin
        val_in = '0;
        ovf_in = '0;
        for (int f = 0; f < FIELDS; f++) begin
            val_in[f] = values[f*VAL_W +: VAL_W];
            ovf_in[f] = 64'(val_in[f]) > MAX_VAL;
        end
    end

    // One double-dabble step: add-3 correction, then shift one binary bit in
    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        tmp   = '0;
        for (int f = 0; f < FIELDS; f++) begin
            tmp = bcd_q[f];
            for (int p = 0; p < DIGITS; p++) begin
                if (tmp[4*p +: 4] >= 4'd5) tmp[4*p +: 4] = tmp[4*p +: 4] + 4'd3;
            end
            bcd_d[f] = {tmp[BCD_W-2:0], bin_q[f][VAL_W-1]};
            bin_d[f] = bin_q[f] << 1;
        end
    end

    // Commit image: overflow saturates to nines, leading zeros optionally blanked
    always_comb begin
        dig_d = dig_q;
        lead  = 1'b0;
        nib   = 4'd0;
        for (int f = 0; f < FIELDS; f++) begin
            lead = lzb_en[f];
            for (int p = DIGITS - 1; p >= 0; p--) begin
                nib = bcd_q[f][4*p +: 4];
                if (ovf_q[f]) begin
                    dig_d[f*DIGITS + p] = 4'd9;
                end else if (lead && (p != 0) && (nib == 4'd0)) begin
                    dig_d[f*DIGITS + p] = 4'hF;
                end else begin
                    dig_d[f*DIGITS + p] = nib;
                    lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= '0;
            busy_q  <= 1'b0;
            dig_q   <= {N{4'hF}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        bin_q   <= val_in;
                        bcd_q   <= '0;
                        ovf_q   <= ovf_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(VAL_W - 1)) state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    dig_q   <= dig_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Drive image for the currently selected digit
    always_comb begin
        data_c = 8'h00;
        com_c  = ~(N'(1) << scan_idx_q);
        for (int d = 0; d < N; d++) begin
            if (scan_idx_q == IDX_W'(d)) begin
                if (blink_en[d / DIGITS] && blink_phase_q) data_c = 8'h00;
                else data_c = {dp_mask[d], seg_enc(dig_q[d])};
            end
        end
    end

    // Scan index, blink timebase and registered outputs; a tick blanks for one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_data_q    <= 8'h00;
            seg_com_q     <= '1;
        end else if (tick_scan) begin
            scan_idx_q <= (scan_idx_q == IDX_W'(N - 1)) ? '0 : scan_idx_q + IDX_W'(1);
            if (blink_cnt_q == BT_W'(BLINK_TICKS - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BT_W'(1);
            end
            seg_data_q <= 8'h00;
            seg_com_q  <= '1;
        end else begin
            seg_data_q <= data_c;
            seg_com_q  <= com_c;
        end
    end

    assign busy     = busy_q;
    assign seg_data = seg_data_q;
    assign seg_com  = seg_com_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench: 2x4-digit instance (BLINK_TICKS=4) and 3x2-digit instance (VAL_W=7).
module tb_seg_scan_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n, tick;
    logic [27:0] values;
    logic        load, busy;
    logic [1:0]  lzb, blink;
    logic [7:0]  dp, seg_data, seg_com;

    logic [20:0] values2;
    logic        load2, busy2;
    logic [2:0]  lzb2, blink2;
    logic [5:0]  dp2, seg_com2;
    logic [7:0]  seg_data2;

    int checks = 0, failures = 0;
    int idx_m = 0, idx2_m = 0, ticks_m = 0;

    seg_scan_display #(.FIELDS(2), .DIGITS(4), .VAL_W(14), .BLINK_TICKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_scan(tick), .values(values), .load(load),
        .busy(busy), .lzb_en(lzb), .blink_en(blink), .dp_mask(dp),
        .seg_data(seg_data), .seg_com(seg_com));

    seg_scan_display #(.FIELDS(3), .DIGITS(2), .VAL_W(7), .BLINK_TICKS(64)) dut2 (
        .clk(clk), .rst_n(rst2_n), .tick_scan(tick), .values(values2), .load(load2),
        .busy(busy2), .lzb_en(lzb2), .blink_en(blink2), .dp_mask(dp2),
        .seg_data(seg_data2), .seg_com(seg_com2));

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        settle();
        tick = 1'b0;
        idx_m   = (idx_m == 7) ? 0 : idx_m + 1;
        idx2_m  = (idx2_m == 5) ? 0 : idx2_m + 1;
        ticks_m = ticks_m + 1;
    endtask

    task automatic advance();
        tick_pulse();
        settle();
    endtask

    task automatic goto_main(input int d);
        for (int i = 0; i < 8 && idx_m != d; i++) advance();
    endtask

    task automatic goto2(input int d);
        for (int i = 0; i < 6 && idx2_m != d; i++) advance();
    endtask

    task automatic load_main(input logic [13:0] v1, input logic [13:0] v0, input logic [1:0] lz,
                             output int cyc);
        values = {v1, v0};
        lzb    = lz;
        load   = 1'b1;
        settle();
        load = 1'b0;
        cyc  = 0;
        while (busy && cyc < 40) begin
            cyc++;
            settle();
        end
        settle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; tick = 1'b0;
        load = 1'b0; values = '0; lzb = '0; blink = '0; dp = '0;
        load2 = 1'b0; values2 = '0; lzb2 = '0; blink2 = '0; dp2 = '0;
        settle(); settle();
        checks++; if (seg_com !== 8'hFF) begin failures++; $display("FAIL rst_com got=%h exp=ff", seg_com); end
        checks++; if (seg_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", seg_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (seg_com2 !== 6'h3F) begin failures++; $display("FAIL rst2_com got=%h exp=3f", seg_com2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rst2_busy got=%b exp=0", busy2); end
        rst_n = 1'b1; rst2_n = 1'b1;
        settle();
        checks++; if (seg_com !== 8'hFE) begin failures++; $display("FAIL rst_d0_com got=%h exp=fe", seg_com); end
        checks++; if (seg_data !== 8'h00) begin failures++; $display("FAIL rst_d0_data got=%h exp=00", seg_data); end
        tick_pulse();
        checks++; if (seg_com !== 8'hFF || seg_data !== 8'h00) begin
            failures++; $display("FAIL ghost com=%h data=%h exp=ff/00", seg_com, seg_data); end
        settle();
        for (int d = 1; d < 8; d++) begin
            if (d > 1) advance();
            checks++; if (seg_com !== ~(8'(1) << d)) begin
                failures++; $display("FAIL rst_scan_com d=%0d got=%h exp=%h", d, seg_com, ~(8'(1) << d)); end
            checks++; if (seg_data !== 8'h00) begin
                failures++; $display("FAIL rst_scan_blank d=%0d got=%h exp=00", d, seg_data); end
        end
    endtask

    task automatic test_convert();
        logic [7:0] exp [8] = '{8'h7D, 8'h6D, 8'h00, 8'h00, 8'h66, 8'h4F, 8'h5B, 8'h06};
        int cyc;
        load_main(14'd1234, 14'd56, 2'b11, cyc);
        checks++; if (cyc !== 15) begin failures++; $display("FAIL busy_len got=%0d exp=15", cyc); end
        for (int d = 7; d >= 0; d--) begin
            goto_main(d);
            checks++; if (seg_com !== ~(8'(1) << d) || seg_data !== exp[d]) begin
                failures++; $display("FAIL conv d=%0d com=%h data=%h exp_data=%h", d, seg_com, seg_data, exp[d]); end
        end
    endtask

    task automatic test_zero();
        logic [7:0] exp [8] = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        int cyc;
        load_main(14'd0, 14'd0, 2'b01, cyc);
        for (int d = 0; d < 8; d++) begin
            goto_main(d);
            checks++; if (seg_data !== exp[d]) begin
                failures++; $display("FAIL zero d=%0d got=%h exp=%h", d, seg_data, exp[d]); end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        load_main(14'd16383, 14'd9999, 2'b11, cyc);
        for (int d = 0; d < 8; d++) begin
            goto_main(d);
            checks++; if (seg_data !== 8'h6F) begin
                failures++; $display("FAIL ovf d=%0d got=%h exp=6f", d, seg_data); end
        end
    endtask

    task automatic test_blink();
        logic [7:0] base [8] = '{8'hFD, 8'h6D, 8'h00, 8'h00, 8'h66, 8'h4F, 8'h5B, 8'h06};
        logic [7:0] e;
        int cyc;
        dp = 8'h01;
        load_main(14'd1234, 14'd56, 2'b11, cyc);
        blink = 2'b01;
        for (int i = 0; i < 24; i++) begin
            advance();
            e = (idx_m < 4 && ((ticks_m / 4) % 2) == 1) ? 8'h00 : base[idx_m];
            checks++; if (seg_data !== e || seg_com !== ~(8'(1) << idx_m)) begin
                failures++; $display("FAIL blink n=%0d d=%0d data=%h exp=%h com=%h", ticks_m, idx_m, seg_data, e, seg_com); end
        end
        blink = 2'b00;
        dp = 8'h00;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            tick_pulse();
            checks++; if (seg_com2 !== 6'h3F || seg_data2 !== 8'h00) begin
                failures++; $display("FAIL wrap_ghost idx=%0d com=%h data=%h", idx2_m, seg_com2, seg_data2); end
            settle();
            checks++; if (seg_com2 !== ~(6'(1) << idx2_m)) begin
                failures++; $display("FAIL wrap_com idx=%0d got=%h exp=%h", idx2_m, seg_com2, ~(6'(1) << idx2_m)); end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] exp_a [6] = '{8'h6D, 8'h00, 8'h66, 8'h4F, 8'h6F, 8'h6F};
        logic [7:0] exp_c [6] = '{8'h6F, 8'h6F, 8'h3F, 8'h00, 8'h07, 8'h00};
        int cyc;
        lzb2 = 3'b111;
        values2 = {7'd120, 7'd34, 7'd5};
        load2 = 1'b1; settle(); load2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 40) begin
            cyc++;
            if (cyc == 3) begin values2 = {7'd1, 7'd2, 7'd3}; load2 = 1'b1; end
            if (cyc == 4) load2 = 1'b0;
            settle();
        end
        load2 = 1'b0;
        checks++; if (cyc !== 8) begin failures++; $display("FAIL busy2_len got=%0d exp=8", cyc); end
        settle();
        for (int d = 0; d < 6; d++) begin
            goto2(d);
            checks++; if (seg_data2 !== exp_a[d]) begin
                failures++; $display("FAIL hs_a d=%0d got=%h exp=%h", d, seg_data2, exp_a[d]); end
        end
        values2 = {7'd120, 7'd34, 7'd5};
        load2 = 1'b1; settle(); load2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 40) begin cyc++; settle(); end
        values2 = {7'd7, 7'd0, 7'd100};
        load2 = 1'b1; settle(); load2 = 1'b0;
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL reload_same_cycle got=%b exp=1", busy2); end
        cyc = 0;
        while (busy2 && cyc < 40) begin cyc++; settle(); end
        settle();
        for (int d = 0; d < 6; d++) begin
            goto2(d);
            checks++; if (seg_data2 !== exp_c[d]) begin
                failures++; $display("FAIL hs_c d=%0d got=%h exp=%h", d, seg_data2, exp_c[d]); end
        end
    endtask

    task automatic test_abort();
        values2 = {7'd42, 7'd42, 7'd42};
        load2 = 1'b1; settle(); load2 = 1'b0;
        settle(); settle(); settle();
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", busy2); end
        rst2_n = 1'b0;
        #1;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy2); end
        checks++; if (seg_com2 !== 6'h3F || seg_data2 !== 8'h00) begin
            failures++; $display("FAIL abort_out com=%h data=%h exp=3f/00", seg_com2, seg_data2); end
        settle();
        rst2_n = 1'b1;
        idx2_m = 0;
        for (int i = 0; i < 20; i++) settle();
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL abort_no_resume got=%b exp=0", busy2); end
        for (int d = 0; d < 6; d++) begin
            goto2(d);
            checks++; if (seg_data2 !== 8'h00 || seg_com2 !== ~(6'(1) << d)) begin
                failures++; $display("FAIL abort_blank d=%0d data=%h com=%h", d, seg_data2, seg_com2); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_zero();
        test_overflow();
        test_wrap();
        test_handshake();
        test_abort();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
